hyp_tanh_exp_post: RTL and testbench
====================================

// Module: hyp_tanh_exp_post
// PURPOSE
//  Downstream stage of the hyperbolic CORDIC rotator: consumes one (sinh, cosh) pair, all values Q2.14 signed (0x4000 = 1.0).
//  Produces exp = cosh + sinh (saturating) plus tanh = sinh / cosh via iterative linear-mode CORDIC division.
//  Completes the hyperbolic/exponential function set of the coordic_algorithm library.
// PARAMETERS
//  N          15   linear CORDIC iterations (shift index i = 0..N-1); 2 <= N <= 16
//  W          16   data width of all ports (Q2.14)
//  GUARD      2    extra LSB/MSB guard bits on internal y/z accumulators
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   one-cycle pulse: sinh_in/cosh_in valid (driven from upstream result state)
//  sinh_in    in   W   sinh(z) Q2.14 signed
//  cosh_in    in   W   cosh(z) Q2.14 signed, expected > 0
//  busy       out  1   high from capture until out_valid cycle inclusive
//  out_valid  out  1   one-cycle pulse: tanh_out/exp_out/flags valid
//  tanh_out   out  W   sinh/cosh Q2.14 signed
//  exp_out    out  W   cosh+sinh Q2.14 signed, saturated
//  exp_sat    out  1   exp_out was clipped
//  div_err    out  1   cosh_in <= 0; tanh_out forced 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, out_valid, exp_sat, div_err = 0; tanh_out, exp_out = 0. Outputs never tristate.
//  FSM IDLE -> ITER -> DONE -> IDLE.
//   IDLE: in_valid=1 -> capture x=cosh_in, y=sinh_in (sign-extended + GUARD), z=0, i=0.
//     Same edge registers exp = cosh_in + sinh_in at W+1 bits; sets exp_sat.
//     Sets div_err if cosh_in <= 0; go ITER (or DONE directly if div_err).
//   ITER: one iteration per clock:
//     y >= 0: y <= y - (x >>> i), z <= z + (ONE >> i)
//     y <  0: y <= y + (x >>> i), z <= z - (ONE >> i)
//     i <= i+1; after iteration i=N-1 go DONE.
//   DONE: tanh_out <= z rounded to W bits; out_valid=1 one cycle; -> IDLE.
//  Latency: out_valid high exactly N+1 cycles after the edge that samples in_valid (N=15: 16); div_err path: 1 cycle.
//  Throughput: one result per N+2 cycles; in_valid while busy is ignored, no queueing, registers untouched.
//  in_valid coincident with DONE: ignored; upstream must not pulse faster.
//  Saturation: exp sum > 0x7FFF -> 0x7FFF; < 0x8000 -> 0x8000; exp_sat=1.
//  Convergence: |sinh/cosh| < 2 guaranteed for valid hyperbolic inputs; tanh_out clamped to [0xC000,0x4000].
//  Accuracy: tanh_out within +-2 LSB of ideal; exp_out exact unless saturated.
//  exp_out/exp_sat/div_err/tanh_out hold last result until next DONE (exp updates at capture).
//  rst mid-ITER: immediate return to IDLE, all outputs to reset values, no out_valid.
// STRUCTURE
//  Shared package hyp_cordic_pkg:
//   FRAC_BITS=14, ONE=16'h4000, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000;
//   state encoding IDLE=0, ITER=1, DONE=2 (2-bit, matches upstream rotator).
//  Sub-module linear_cordic_step: combinational (x, y, z, i) -> (y', z').
//  Top holds FSM, iteration counter, capture regs, exp adder/saturator, output regs.
// TESTING
//  1. sinh=0x0000, cosh=0x4000 -> tanh_out=0x0000+-2, exp_out=0x4000, flags 0; out_valid 16 cycles after in_valid.
//  2. sinh=0x2000, cosh=0x4000 -> tanh_out=0x2000+-2, exp_out=0x6000.
//  3. sinh=0xE000, cosh=0x4000 -> tanh_out=0xE000+-2, exp_out=0x2000.
//  4. sinh=0x7000, cosh=0x7000 -> exp_out=0x7FFF, exp_sat=1, tanh_out=0x4000+-2.
//  5. cosh=0x0000 -> div_err=1, tanh_out=0, out_valid 1 cycle after capture.
//     Then second in_valid pulse during busy is ignored.
//  6. rst asserted at iteration 7 -> outputs 0 same cycle, no out_valid.
//     Next in_valid(0x2000,0x4000) completes normally.

Source files
------------

// File: rtl/hyp_cordic_pkg.sv
// Shared constants and state encoding for the hyperbolic CORDIC stages (Q2.14 data).
package hyp_cordic_pkg;

  localparam int          FRAC_BITS = 14;
  localparam logic [15:0] ONE       = 16'h4000;
  localparam logic [15:0] SAT_MAX   = 16'h7FFF;
  localparam logic [15:0] SAT_MIN   = 16'h8000;

  // Encoding kept identical to the upstream rotator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/linear_cordic_step.sv
// One linear-mode (division) CORDIC micro-rotation: drives y toward 0, accumulating y0/x in z.
module linear_cordic_step
  import hyp_cordic_pkg::*;
#(
  parameter int GUARD = 2,
  parameter int IW    = 20,
  parameter int IDXW  = 4
) (
  input  logic signed [IW-1:0]   i_x,
  input  logic signed [IW-1:0]   i_y,
  input  logic signed [IW-1:0]   i_z,
  input  logic        [IDXW-1:0] i_idx,
  output logic signed [IW-1:0]   o_y,
  output logic signed [IW-1:0]   o_z
);

  // 1.0 in the internal format, which carries GUARD extra fraction bits.
  localparam logic signed [IW-1:0] L_ONE = IW'(1) << (FRAC_BITS + GUARD);

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_zs;

  always_comb begin
    w_xs = i_x >>> i_idx;
    w_zs = L_ONE >>> i_idx;
    o_y  = i_y;
    o_z  = i_z;
    if (!i_y[IW-1]) begin
      o_y = i_y - w_xs;
      o_z = i_z + w_zs;
    end else begin
      o_y = i_y + w_xs;
      o_z = i_z - w_zs;
    end
  end

endmodule

// File: rtl/hyp_tanh_exp_post.sv
// Post-stage of the hyperbolic rotator: exp = cosh + sinh (saturating) and
// tanh = sinh / cosh by iterative linear CORDIC division.
module hyp_tanh_exp_post
  import hyp_cordic_pkg::*;
#(
  parameter int N     = 15,
  parameter int W     = 16,
  parameter int GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] sinh_in,
  input  logic [W-1:0] cosh_in,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] tanh_out,
  output logic [W-1:0] exp_out,
  output logic         exp_sat,
  output logic         div_err
);

  localparam int IW = W + 2 * GUARD;
  localparam int CW = 4;

  localparam logic signed [IW-1:0] L_TMAX = IW'(ONE);
  localparam logic signed [IW-1:0] L_TMIN = -L_TMAX;
  localparam logic signed [IW-1:0] L_RND  = IW'(1) << (GUARD - 1);

  state_t               r_state;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [IW-1:0] r_z;
  logic [CW-1:0]        r_i;
  logic                 r_err_pend;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [W-1:0]         r_tanh;
  logic [W-1:0]         r_exp;
  logic                 r_exp_sat;
  logic                 r_div_err;

  logic signed [W:0]    w_sum;
  logic                 w_sum_ovf;
  logic [W-1:0]         w_exp;
  logic                 w_cosh_bad;
  logic signed [IW-1:0] w_y_nxt;
  logic signed [IW-1:0] w_z_nxt;
  logic signed [IW-1:0] w_z_rnd;
  logic signed [IW-1:0] w_z_q;
  logic [W-1:0]         w_tanh;

  // Overflow of the W+1-bit sum shows up as disagreement of the two top bits.
  assign w_sum      = $signed({sinh_in[W-1], sinh_in}) + $signed({cosh_in[W-1], cosh_in});
  assign w_sum_ovf  = w_sum[W] ^ w_sum[W-1];
  assign w_exp      = w_sum_ovf ? (w_sum[W] ? W'(SAT_MIN) : W'(SAT_MAX)) : w_sum[W-1:0];
  assign w_cosh_bad = cosh_in[W-1] | (cosh_in == '0);

  assign w_z_rnd = r_z + L_RND;
  assign w_z_q   = w_z_rnd >>> GUARD;

  always_comb begin
    w_tanh = w_z_q[W-1:0];
    if (w_z_q > L_TMAX) begin
      w_tanh = W'(L_TMAX);
    end else if (w_z_q < L_TMIN) begin
      w_tanh = W'(L_TMIN);
    end
  end

  linear_cordic_step #(
    .GUARD (GUARD),
    .IW    (IW),
    .IDXW  (CW)
  ) u_step (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_z   (r_z),
    .i_idx (r_i),
    .o_y   (w_y_nxt),
    .o_z   (w_z_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_i         <= '0;
      r_err_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_tanh      <= '0;
      r_exp       <= '0;
      r_exp_sat   <= 1'b0;
      r_div_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            r_x        <= {{GUARD{cosh_in[W-1]}}, cosh_in, {GUARD{1'b0}}};
            r_y        <= {{GUARD{sinh_in[W-1]}}, sinh_in, {GUARD{1'b0}}};
            r_z        <= '0;
            r_i        <= '0;
            r_exp      <= w_exp;
            r_exp_sat  <= w_sum_ovf;
            r_err_pend <= w_cosh_bad;
            r_busy     <= 1'b1;
            r_state    <= w_cosh_bad ? DONE : ITER;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ITER: begin
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + CW'(1);
          if (r_i == CW'(N - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // busy stays high through the out_valid cycle; IDLE drops it next edge.
          r_tanh      <= r_err_pend ? '0 : w_tanh;
          r_div_err   <= r_err_pend;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign tanh_out  = r_tanh;
  assign exp_out   = r_exp;
  assign exp_sat   = r_exp_sat;
  assign div_err   = r_div_err;

endmodule

// File: tb/tb_hyp_tanh_exp_post.sv
// Self-checking bench for hyp_tanh_exp_post: directed cases plus randomized
// transactions against a real-arithmetic reference for tanh and exp.
module tb_hyp_tanh_exp_post;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] sinh_in = '0;
  logic [15:0] cosh_in = '0;
  logic        busy;
  logic        out_valid;
  logic [15:0] tanh_out;
  logic [15:0] exp_out;
  logic        exp_sat;
  logic        div_err;

  int checks = 0;
  int errors = 0;

  hyp_tanh_exp_post #(.N(15), .W(16), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sinh_in   (sinh_in),
    .cosh_in   (cosh_in),
    .busy      (busy),
    .out_valid (out_valid),
    .tanh_out  (tanh_out),
    .exp_out   (exp_out),
    .exp_sat   (exp_sat),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_tanh(input int s, input int c);
    real r;
    int  q;
    r = (s * 16384.0) / c;
    q = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
    if (q > 16384)  q = 16384;
    if (q < -16384) q = -16384;
    return q;
  endfunction

  function automatic int ref_exp(input int s, input int c);
    int sum;
    sum = s + c;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  function automatic bit ref_sat(input int s, input int c);
    return (s + c > 32767) || (s + c < -32768);
  endfunction

  // Drives one capture and waits (bounded) for out_valid; lat = -1 on timeout.
  task automatic run_txn(input logic [15:0] s, input logic [15:0] c,
                         output int lat, output logic [15:0] t, output logic [15:0] e,
                         output logic sat, output logic err,
                         output logic busy_cap, output logic busy_ov);
    @(negedge clk);
    sinh_in  = s;
    cosh_in  = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy_cap = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    t = tanh_out;
    e = exp_out;
    sat = exp_sat;
    err = div_err;
    busy_ov = busy;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, out_valid, exp_sat, div_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, out_valid, exp_sat, div_err});
    end
    checks++;
    if ({tanh_out, exp_out} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got tanh=%h exp=%h exp=0000/0000", tanh_out, exp_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] sv [4] = '{16'h0000, 16'h2000, 16'hE000, 16'h7000};
    logic [15:0] cv [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h7000};
    int lat, d;
    logic [15:0] t, e;
    logic sat, err, bc, bo;
    for (int n = 0; n < 4; n++) begin
      run_txn(sv[n], cv[n], lat, t, e, sat, err, bc, bo);
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d exp=16", n, lat);
      end
      d = int'($signed(t)) - ref_tanh(int'($signed(sv[n])), int'($signed(cv[n])));
      checks++;
      if (d > 2 || d < -2) begin
        errors++;
        $display("FAIL dir%0d_tanh got=%h exp=%h+-2", n, t,
                 16'(ref_tanh(int'($signed(sv[n])), int'($signed(cv[n])))));
      end
      checks++;
      if (e !== 16'(ref_exp(int'($signed(sv[n])), int'($signed(cv[n]))))) begin
        errors++;
        $display("FAIL dir%0d_exp got=%h exp=%h", n, e,
                 16'(ref_exp(int'($signed(sv[n])), int'($signed(cv[n])))));
      end
      checks++;
      if ({sat, err, bc, bo} !== {ref_sat(int'($signed(sv[n])), int'($signed(cv[n]))), 3'b011}) begin
        errors++;
        $display("FAIL dir%0d_flags got sat/err/busy/busy_ov=%b", n, {sat, err, bc, bo});
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_after got busy=%b ov=%b exp=0 0", n, busy, out_valid);
      end
    end
  endtask

  task automatic test_div_err_and_busy;
    int lat;
    logic [15:0] t, e;
    logic sat, err, bc, bo;
    run_txn(16'h1234, 16'h0000, lat, t, e, sat, err, bc, bo);
    checks++;
    if (lat !== 1 || err !== 1'b1 || t !== 16'h0000 || e !== 16'h1234 || bo !== 1'b1) begin
      errors++;
      $display("FAIL diverr_zero got lat=%0d err=%b tanh=%h exp=%h busy=%b exp=1 1 0000 1234 1",
               lat, err, t, e, bo);
    end
    run_txn(16'h0100, 16'h8000, lat, t, e, sat, err, bc, bo);
    checks++;
    if (lat !== 1 || err !== 1'b1 || t !== 16'h0000 || sat !== 1'b0 || e !== 16'h8100) begin
      errors++;
      $display("FAIL diverr_neg got lat=%0d err=%b tanh=%h sat=%b exp=%h exp=1 1 0000 0 8100",
               lat, err, t, sat, e);
    end
    // Normal transaction with a stray pulse injected mid-iteration.
    @(negedge clk);
    sinh_in = 16'h2000;
    cosh_in = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        sinh_in = 16'h7000;
        cosh_in = 16'h7000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (k == 3) begin
        checks++;
        if (div_err !== 1'b1 || exp_out !== 16'h6000) begin
          errors++;
          $display("FAIL hold_mid got div_err=%b exp=%h exp=1 6000", div_err, exp_out);
        end
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL ignore_latency got=%0d exp=16", lat);
    end
    checks++;
    if (exp_out !== 16'h6000 || exp_sat !== 1'b0 || div_err !== 1'b0 ||
        int'($signed(tanh_out)) > 8194 || int'($signed(tanh_out)) < 8190) begin
      errors++;
      $display("FAIL ignore_result got tanh=%h exp=%h sat=%b err=%b exp=2000+-2 6000 0 0",
               tanh_out, exp_out, exp_sat, div_err);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random;
    int s, c, lat, d;
    logic [15:0] t, e;
    logic sat, err, bc, bo;
    for (int n = 0; n < 24; n++) begin
      c = int'($urandom_range(32767, 16384));
      s = int'($urandom_range(2 * c - 2, 0)) - (c - 1);
      run_txn(16'(s), 16'(c), lat, t, e, sat, err, bc, bo);
      d = int'($signed(t)) - ref_tanh(s, c);
      checks++;
      if (lat !== 16 || err !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_timing got lat=%0d err=%b exp=16 0", n, lat, err);
      end
      checks++;
      if (d > 2 || d < -2) begin
        errors++;
        $display("FAIL rnd%0d_tanh s=%h c=%h got=%h exp=%h+-2", n, 16'(s), 16'(c), t, 16'(ref_tanh(s, c)));
      end
      checks++;
      if (e !== 16'(ref_exp(s, c)) || sat !== ref_sat(s, c)) begin
        errors++;
        $display("FAIL rnd%0d_exp s=%h c=%h got=%h/%b exp=%h/%b", n, 16'(s), 16'(c), e, sat,
                 16'(ref_exp(s, c)), ref_sat(s, c));
      end
    end
  endtask

  task automatic test_reset_mid_iter;
    int lat, seen;
    logic [15:0] t, e;
    logic sat, err, bc, bo;
    @(negedge clk);
    sinh_in = 16'h7000;
    cosh_in = 16'h7000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, exp_sat, div_err, tanh_out, exp_out} !== 36'h0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b ov=%b sat=%b err=%b tanh=%h exp=%h exp=all zero",
               busy, out_valid, exp_sat, div_err, tanh_out, exp_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_out got active_cycles=%0d exp=0", seen);
    end
    run_txn(16'h2000, 16'h4000, lat, t, e, sat, err, bc, bo);
    checks++;
    if (lat !== 16 || e !== 16'h6000 || sat !== 1'b0 || err !== 1'b0 ||
        int'($signed(t)) > 8194 || int'($signed(t)) < 8190) begin
      errors++;
      $display("FAIL rst_recover got lat=%0d tanh=%h exp=%h sat=%b err=%b exp=16 2000+-2 6000 0 0",
               lat, t, e, sat, err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_err_and_busy();
    test_random();
    test_reset_mid_iter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
